// File: rtl/mem_io_responder_if.sv
// CPU data-port bus between the core (master) and the memory/I-O responder (slave).
// rdata is combinational in the responder and is valid in the same cycle as read.
interface mem_io_responder_if;
    logic       read;
    logic       write;
    logic [7:0] address;
    logic [7:0] wdata;
    logic [7:0] rdata;

    modport master (output read, output write, output address, output wdata, input rdata);
    modport slave  (input read, input write, input address, input wdata, output rdata);
endinterface

// File: rtl/mem_io_responder.sv
// Bus responder for the CPU data port: 240-byte data RAM plus memory-mapped LED,
// switch, TX FIFO and timer registers in the top of the 8-bit address space.
module mem_io_responder #(
    parameter int RAM_WORDS  = 240,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    mem_io_responder_if.slave        bus,
    input  logic [7:0]               sw_in,
    output logic [7:0]               led_out,
    output logic [7:0]               tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic                     irq
);
    localparam logic [7:0] ADDR_LED    = 8'hF0;
    localparam logic [7:0] ADDR_SW     = 8'hF1;
    localparam logic [7:0] ADDR_TX     = 8'hF2;
    localparam logic [7:0] ADDR_STATUS = 8'hF3;
    localparam logic [7:0] ADDR_RELOAD = 8'hF4;
    localparam logic [7:0] ADDR_COUNT  = 8'hF5;
    localparam logic [7:0] ADDR_CTRL   = 8'hF6;

    localparam int             PW        = $clog2(FIFO_DEPTH);
    localparam logic [PW:0]    FIFO_FULL = (PW + 1)'(FIFO_DEPTH);

    logic [7:0]    ram [RAM_WORDS];
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   fifo_count;
    logic [7:0]    sw_sync1, sw_sync2;
    logic [7:0]    reload, tcount;
    logic          timer_en, timer_flag, overflow;

    logic wr_en, rd_en, is_ram;
    logic fifo_full, fifo_empty, fifo_push, fifo_pop, fifo_accept;
    logic reload_wr, status_rd, timer_wrap;
    logic [7:0] status, rdata_c;

    // A simultaneous read+write is treated as a pure write: no read data, no read side effects.
    assign wr_en  = bus.write;
    assign rd_en  = bus.read & ~bus.write;
    assign is_ram = int'(bus.address) < RAM_WORDS;

    assign fifo_full   = (fifo_count == FIFO_FULL);
    assign fifo_empty  = (fifo_count == '0);
    assign fifo_push   = wr_en && (bus.address == ADDR_TX);
    assign fifo_pop    = tx_valid & tx_ready;
    assign fifo_accept = fifo_push & (~fifo_full | fifo_pop);

    assign reload_wr  = wr_en && (bus.address == ADDR_RELOAD);
    assign status_rd  = rd_en && (bus.address == ADDR_STATUS);
    assign timer_wrap = timer_en && (tcount == 8'h00);

    assign status   = {4'b0000, overflow, timer_flag, fifo_empty, fifo_full};
    assign tx_valid = ~fifo_empty;
    assign tx_data  = fifo_empty ? 8'h00 : fifo_mem[rd_ptr];
    assign irq      = timer_flag;

    always_ff @(posedge clk) begin
        if (wr_en && is_ram)
            ram[bus.address] <= bus.wdata;
    end

    always_comb begin
        rdata_c = 8'h00;
        if (rd_en) begin
            if (is_ram) rdata_c = ram[bus.address];
            else begin
                case (bus.address)
                    ADDR_LED:    rdata_c = led_out;
                    ADDR_SW:     rdata_c = sw_sync2;
                    ADDR_STATUS: rdata_c = status;
                    ADDR_RELOAD: rdata_c = reload;
                    ADDR_COUNT:  rdata_c = tcount;
                    ADDR_CTRL:   rdata_c = {7'b0, timer_en};
                    default:     rdata_c = 8'h00;
                endcase
            end
        end
    end
    assign bus.rdata = rdata_c;

    // A push into a full FIFO is still accepted when the head leaves on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= 8'h00;
        end else begin
            if (fifo_accept) begin
                fifo_mem[wr_ptr] <= bus.wdata;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (fifo_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({fifo_accept, fifo_pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led_out  <= 8'h00;
            timer_en <= 1'b0;
            overflow <= 1'b0;
            sw_sync1 <= 8'h00;
            sw_sync2 <= 8'h00;
        end else begin
            sw_sync1 <= sw_in;
            sw_sync2 <= sw_sync1;
            if (wr_en && bus.address == ADDR_LED)  led_out  <= bus.wdata;
            if (wr_en && bus.address == ADDR_CTRL) timer_en <= bus.wdata[0];
            if (fifo_push && fifo_full && !fifo_pop)           overflow <= 1'b1;
            else if (wr_en && bus.address == ADDR_STATUS)      overflow <= 1'b0;
        end
    end

    // A RELOAD write beats the wrap reload, and a wrap beats a STATUS-read clear of the flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reload     <= 8'hFF;
            tcount     <= 8'hFF;
            timer_flag <= 1'b0;
        end else begin
            if (reload_wr) begin
                reload <= bus.wdata;
                tcount <= bus.wdata;
            end else if (timer_wrap) begin
                tcount <= reload;
            end else if (timer_en) begin
                tcount <= tcount - 1'b1;
            end
            if (timer_wrap)     timer_flag <= 1'b1;
            else if (status_rd) timer_flag <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mem_io_responder.sv
// Self-checking bench for mem_io_responder: bus reads and the TX byte stream are
// checked against expectations queued when the stimulus is driven.
module tb_mem_io_responder;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] sw_in;
    logic [7:0] led_out, tx_data;
    logic       tx_valid, tx_ready, irq;
    int         total = 0;
    int         bad   = 0;
    logic [7:0] exp_rd [$];
    logic [7:0] exp_tx [$];

    mem_io_responder_if bus ();

    mem_io_responder #(.RAM_WORDS(240), .FIFO_DEPTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave),
        .sw_in    (sw_in),
        .led_out  (led_out),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    task automatic do_read(input logic [7:0] a, output logic [7:0] d);
        @(negedge clk);
        bus.read = 1'b1; bus.write = 1'b0; bus.address = a;
        #1 d = bus.rdata;
        @(posedge clk);
        #1 bus.read = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] v);
        @(negedge clk);
        bus.write = 1'b1; bus.read = 1'b0; bus.address = a; bus.wdata = v;
        @(posedge clk);
        #1 bus.write = 1'b0;
    endtask

    task automatic test_reset;
        logic [7:0] addrs [4] = '{8'hF0, 8'hF3, 8'hF4, 8'hF5};
        logic [7:0] vals  [4] = '{8'h00, 8'h02, 8'hFF, 8'hFF};
        logic [7:0] got, e;
        #1;
        total++;
        if (led_out !== 8'h00 || tx_valid !== 1'b0 || tx_data !== 8'h00 || irq !== 1'b0 || bus.rdata !== 8'h00) begin
            bad++;
            $display("[TB] FAIL reset_outputs got led=%h txv=%b txd=%h irq=%b rdata=%h exp 00 0 00 0 00",
                     led_out, tx_valid, tx_data, irq, bus.rdata);
        end
        for (int i = 0; i < 4; i++) begin
            exp_rd.push_back(vals[i]);
            do_read(addrs[i], got);
            e = exp_rd.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("[TB] FAIL reset_read[%h] got %h exp %h", addrs[i], got, e);
            end
        end
    endtask

    task automatic test_ram;
        logic [7:0] addrs [4] = '{8'h00, 8'hEF, 8'hF8, 8'hF2};
        logic [7:0] vals  [4] = '{8'h5A, 8'hA5, 8'h00, 8'h00};
        logic [7:0] got, e;
        do_write(8'h00, 8'h5A);
        do_write(8'hEF, 8'hA5);
        for (int i = 0; i < 4; i++) begin
            exp_rd.push_back(vals[i]);
            do_read(addrs[i], got);
            e = exp_rd.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("[TB] FAIL ram_read[%h] got %h exp %h", addrs[i], got, e);
            end
        end
        do_write(8'hF8, 8'h3C);
        exp_rd.push_back(8'hA5);
        do_read(8'hEF, got);
        e = exp_rd.pop_front();
        total++;
        if (got !== e) begin
            bad++;
            $display("[TB] FAIL ram_after_unmapped_write got %h exp %h", got, e);
        end
    endtask

    task automatic test_fifo;
        logic [7:0] got, e;
        int guard;
        tx_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            exp_tx.push_back(8'(i * 8'h11));
            do_write(8'hF2, 8'(i * 8'h11));
        end
        exp_rd.push_back(8'h01);
        do_read(8'hF3, got);
        e = exp_rd.pop_front();
        total++;
        if (got !== e) begin bad++; $display("[TB] FAIL fifo_status_full got %h exp %h", got, e); end
        do_write(8'hF2, 8'h55);
        exp_rd.push_back(8'h09);
        do_read(8'hF3, got);
        e = exp_rd.pop_front();
        total++;
        if (got !== e) begin bad++; $display("[TB] FAIL fifo_status_overflow got %h exp %h", got, e); end

        @(negedge clk);
        tx_ready = 1'b1;
        guard = 0;
        while (exp_tx.size() > 0 && guard < 20) begin
            #1;
            if (tx_valid) begin
                e = exp_tx.pop_front();
                total++;
                if (tx_data !== e) begin bad++; $display("[TB] FAIL fifo_drain got %h exp %h", tx_data, e); end
            end
            guard++;
            if (exp_tx.size() > 0) @(negedge clk);
        end
        if (guard >= 20) begin
            total++; bad++;
            $display("[TB] FAIL fifo_drain_timeout got %0d left exp 0", exp_tx.size());
            exp_tx.delete();
        end
        @(negedge clk);
        #1;
        total++;
        if (tx_valid !== 1'b0) begin bad++; $display("[TB] FAIL fifo_empty_after_drain got %b exp 0", tx_valid); end
        tx_ready = 1'b0;

        do_write(8'hF3, 8'hFF);
        exp_rd.push_back(8'h02);
        do_read(8'hF3, got);
        e = exp_rd.pop_front();
        total++;
        if (got !== e) begin bad++; $display("[TB] FAIL fifo_overflow_clear got %h exp %h", got, e); end
    endtask

    task automatic test_fifo_full_pushpop;
        logic [7:0] got, e;
        int guard;
        tx_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            exp_tx.push_back(8'hA0 + 8'(i));
            do_write(8'hF2, 8'hA0 + 8'(i));
        end
        @(negedge clk);
        bus.write = 1'b1; bus.address = 8'hF2; bus.wdata = 8'h66; tx_ready = 1'b1;
        #1;
        e = exp_tx.pop_front();
        exp_tx.push_back(8'h66);
        total++;
        if (tx_data !== e) begin bad++; $display("[TB] FAIL pushpop_head got %h exp %h", tx_data, e); end
        @(posedge clk);
        #1 bus.write = 1'b0; tx_ready = 1'b0;

        exp_rd.push_back(8'h01);
        do_read(8'hF3, got);
        e = exp_rd.pop_front();
        total++;
        if (got !== e) begin bad++; $display("[TB] FAIL pushpop_status got %h exp %h", got, e); end

        @(negedge clk);
        tx_ready = 1'b1;
        guard = 0;
        while (exp_tx.size() > 0 && guard < 20) begin
            #1;
            if (tx_valid) begin
                e = exp_tx.pop_front();
                total++;
                if (tx_data !== e) begin bad++; $display("[TB] FAIL pushpop_drain got %h exp %h", tx_data, e); end
            end
            guard++;
            if (exp_tx.size() > 0) @(negedge clk);
        end
        if (guard >= 20) begin
            total++; bad++;
            $display("[TB] FAIL pushpop_drain_timeout got %0d left exp 0", exp_tx.size());
            exp_tx.delete();
        end
        @(negedge clk);
        #1;
        total++;
        if (tx_valid !== 1'b0) begin bad++; $display("[TB] FAIL pushpop_empty got %b exp 0", tx_valid); end
        tx_ready = 1'b0;
    endtask

    task automatic test_timer;
        logic [7:0] got, e;
        logic exp_irq;
        do_write(8'hF4, 8'h03);
        do_write(8'hF6, 8'h01);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            exp_irq = (k == 4);
            total++;
            if (irq !== exp_irq) begin bad++; $display("[TB] FAIL timer_first_period[%0d] got %b exp %b", k, irq, exp_irq); end
        end
        exp_rd.push_back(8'h06);
        do_read(8'hF3, got);
        e = exp_rd.pop_front();
        total++;
        if (got !== e) begin bad++; $display("[TB] FAIL timer_status_read got %h exp %h", got, e); end
        total++;
        if (irq !== 1'b0) begin bad++; $display("[TB] FAIL timer_flag_clear got %b exp 0", irq); end
        for (int k = 6; k <= 8; k++) begin
            @(posedge clk);
            #1;
            exp_irq = (k == 8);
            total++;
            if (irq !== exp_irq) begin bad++; $display("[TB] FAIL timer_second_period[%0d] got %b exp %b", k, irq, exp_irq); end
        end
        repeat (3) @(posedge clk);
        exp_rd.push_back(8'h06);
        do_read(8'hF3, got);
        e = exp_rd.pop_front();
        total++;
        if (got !== e) begin bad++; $display("[TB] FAIL timer_status_on_wrap got %h exp %h", got, e); end
        total++;
        if (irq !== 1'b1) begin bad++; $display("[TB] FAIL timer_set_beats_clear got %b exp 1", irq); end

        exp_rd.push_back(8'h03);
        do_read(8'hF5, got);
        e = exp_rd.pop_front();
        total++;
        if (got !== e) begin bad++; $display("[TB] FAIL timer_count_after_wrap got %h exp %h", got, e); end
        do_write(8'hF6, 8'h00);
        for (int i = 0; i < 2; i++) begin
            exp_rd.push_back(8'h01);
            do_read(8'hF5, got);
            e = exp_rd.pop_front();
            total++;
            if (got !== e) begin bad++; $display("[TB] FAIL timer_count_hold[%0d] got %h exp %h", i, got, e); end
            repeat (3) @(posedge clk);
        end
        exp_rd.push_back(8'h06);
        do_read(8'hF3, got);
        e = exp_rd.pop_front();
        total++;
        if (got !== e || irq !== 1'b0) begin
            bad++;
            $display("[TB] FAIL timer_final_clear got status=%h irq=%b exp %h 0", got, irq, e);
        end
    endtask

    task automatic test_switch_priority;
        logic [7:0] got, e;
        @(negedge clk);
        sw_in = 8'hC3;
        exp_rd.push_back(8'h00);
        exp_rd.push_back(8'hC3);
        for (int i = 0; i < 2; i++) begin
            do_read(8'hF1, got);
            e = exp_rd.pop_front();
            total++;
            if (got !== e) begin bad++; $display("[TB] FAIL switch_sync[%0d] got %h exp %h", i, got, e); end
        end
        @(negedge clk);
        bus.read = 1'b1; bus.write = 1'b1; bus.address = 8'hF0; bus.wdata = 8'h7E;
        #1;
        total++;
        if (bus.rdata !== 8'h00) begin bad++; $display("[TB] FAIL rw_priority_rdata got %h exp 00", bus.rdata); end
        @(posedge clk);
        #1 bus.read = 1'b0; bus.write = 1'b0;
        total++;
        if (led_out !== 8'h7E) begin bad++; $display("[TB] FAIL rw_priority_led got %h exp 7E", led_out); end
    endtask

    task automatic test_reset_mid;
        logic [7:0] addrs [4] = '{8'hF5, 8'hF0, 8'h00, 8'hF3};
        logic [7:0] vals  [4] = '{8'hFF, 8'h00, 8'h5A, 8'h02};
        logic [7:0] got, e;
        do_write(8'hF2, 8'h31);
        do_write(8'hF2, 8'h32);
        @(negedge clk);
        tx_ready = 1'b1;
        #1;
        total++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h31) begin
            bad++;
            $display("[TB] FAIL reset_mid_before got txv=%b txd=%h exp 1 31", tx_valid, tx_data);
        end
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        total++;
        if (tx_valid !== 1'b0 || tx_data !== 8'h00 || led_out !== 8'h00) begin
            bad++;
            $display("[TB] FAIL reset_mid_async got txv=%b txd=%h led=%h exp 0 00 00", tx_valid, tx_data, led_out);
        end
        @(negedge clk);
        rst = 1'b1;
        tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_rd.push_back(vals[i]);
            do_read(addrs[i], got);
            e = exp_rd.pop_front();
            total++;
            if (got !== e) begin bad++; $display("[TB] FAIL reset_mid_read[%h] got %h exp %h", addrs[i], got, e); end
        end
    endtask

    initial begin
        rst = 1'b0;
        sw_in = 8'h00;
        tx_ready = 1'b0;
        bus.read = 1'b0; bus.write = 1'b0; bus.address = 8'h00; bus.wdata = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        test_reset();
        test_ram();
        test_fifo();
        test_fifo_full_pushpop();
        test_timer();
        test_switch_priority();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_io_responder.md
# mem_io_responder

Bus responder on the far side of the CPU data port. It answers every `read` and `write` request the CPU issues and decodes the 8-bit address space into three regions: 240 bytes of data RAM, a set of memory-mapped I/O registers, and an unmapped range. The I/O registers are an LED output register, a synchronized switch input, a 4-deep byte-stream TX FIFO and a reloadable down-counter timer.

## Interface
- RAM_WORDS, 240: data RAM depth; occupies addresses 0x00–0xEF.
- FIFO_DEPTH, 4: TX FIFO entries; must be a power of 2.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-low.
- read  input  1  CPU read request, valid for one cycle.
- write  input  1  CPU write request, valid for one cycle.
- address  input  8  request address.
- wdata  input  8  write data (CPU `dout`).
- rdata  output  8  read data (CPU `din`); combinational.
- sw_in  input  8  asynchronous switch inputs.
- led_out  output  8  LED register.
- tx_data  output  8  FIFO head byte.
- tx_valid  output  1  FIFO non-empty.
- tx_ready  input  1  consumer accepts the head byte when `tx_valid & tx_ready`.
- irq  output  1  equals the timer flag.

## Operation
- Address map:
  - 0x00–0xEF: RAM, read/write.
  - 0xF0: LED, read/write.
  - 0xF1: switches, read-only.
  - 0xF2: TX FIFO push, write-only; reads return 0x00.
  - 0xF3: STATUS, read/write.
  - 0xF4: RELOAD, read/write.
  - 0xF5: COUNT, read-only.
  - 0xF6: CTRL, read/write; bit0 = enable, other bits read 0.
  - 0xF7–0xFF: unmapped; reads return 0x00, writes ignored.
- STATUS bit layout:
  - bit0 = fifo_full.
  - bit1 = fifo_empty.
  - bit2 = timer_flag.
  - bit3 = overflow (sticky).
  - bits 7:4 = 0.
- rdata:
  - Combinational decode of `address` while `read=1`.
  - 0x00 when `read=0`.
  - 0x00 when `read` and `write` are both high.
- read and write both high: the write is performed and the read is ignored; no read side effects occur.
- Write side effects:
  - RELOAD write loads both RELOAD and COUNT.
  - STATUS write (any data) clears overflow only.
  - Writes to read-only addresses are ignored.
- Read side effect: a STATUS read clears timer_flag at the edge that ends the read cycle. The value returned is the flag before the clear.
- FIFO:
  - Circular buffer with wrapping read/write pointers and an occupancy count of width log2(FIFO_DEPTH)+1.
  - Push when full: byte dropped, overflow set.
  - Push and pop in the same cycle when full: both happen, the byte is accepted and count is unchanged.
  - Pop only when `tx_valid`.
- Switch input: 2-flop synchronizer; the 0xF1 read returns the second stage.
- Timer, when enabled:
  - COUNT decrements by 1 each cycle.
  - When COUNT==0, the next edge loads RELOAD into COUNT and sets timer_flag.
  - RELOAD=0 sets the flag every cycle.
  - If a flag set and a STATUS-read clear land on the same edge, the set wins.
  - A RELOAD write in the same cycle as COUNT==0 wins: COUNT gets wdata and the flag is still set.
  - When disabled, COUNT holds its value.
- RAM: asynchronous read; synchronous write; contents not reset.

## Timing
- Reset values:
  - led_out 0x00.
  - FIFO empty, so tx_valid 0 and tx_data 0x00.
  - RELOAD 0xFF, COUNT 0xFF.
  - CTRL 0.
  - timer_flag 0, irq 0, overflow 0.
  - Synchronizer flops 0.
  - rdata 0x00.
- Reset asserted mid-operation clears all of the above immediately, including FIFO contents. RAM is unaffected.
- Read latency is 0 cycles: rdata is valid in the cycle `read=1` and is sampled by the CPU at the following edge.
- Write latency is 1 edge: the written value is visible to a read in the next cycle.
- led_out, tx_valid and irq are registered; each changes on the edge after the causing write or event.
- A push to an empty FIFO gives `tx_valid=1` on the next cycle. There is no same-cycle bypass.
- Switch change to readable value: 2 edges.
- Timer period: RELOAD+1 cycles between flag sets.

## Test plan
- Reset release, then read 0xF0, 0xF3, 0xF4 and 0xF5 -> 0x00, 0x02, 0xFF, 0xFF; led_out=0, tx_valid=0.
- RAM: write 0x5A to 0x00, then 0xA5 to 0xEF; read back both -> 0x5A, 0xA5. Read 0xF8 -> 0x00. Write 0xF8, then re-read 0xEF -> still 0xA5.
- FIFO with tx_ready=0:
  - Push 0x11, 0x22, 0x33, 0x44 -> STATUS=0x01.
  - Push 0x55 -> STATUS=0x09.
  - Raise tx_ready -> tx_data order 0x11, 0x22, 0x33, 0x44, then tx_valid=0.
  - Write STATUS -> overflow cleared, STATUS=0x02.
- FIFO full plus simultaneous pop and push of 0x66 -> count stays 4, overflow stays 0, 0x66 is last out.
- Timer:
  - Write RELOAD=3, CTRL=1 -> irq rises 4 cycles after the enable edge and repeats every 4 cycles.
  - Read STATUS -> returns bit2=1 and irq drops next edge, unless that edge is a wrap.
- Switches and priority:
  - sw_in=0xC3 -> 0xF1 reads 0xC3 from the 2nd edge on.
  - read+write to 0xF0 with 0x7E -> rdata=0x00, led_out=0x7E.
  - Assert rst mid-FIFO-drain -> tx_valid=0 immediately.
